// File: rtl/dispatch_ctrl.sv
// Dispatch-stage controller: in-order, credit-gated dispatch of up to WIDTH decoded
// slots per cycle, with halt/illegal shutdown and squash recovery sequencing.
module dispatch_ctrl #(
  parameter  int WIDTH    = 3,
  parameter  int ROB_SIZE = 32,
  parameter  int RS_SIZE  = 16,
  parameter  int LSQ_SIZE = 8,
  localparam int ROB_W    = $clog2(ROB_SIZE + 1),
  localparam int RS_W     = $clog2(RS_SIZE + 1),
  localparam int LSQ_W    = $clog2(LSQ_SIZE + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dec_valid,
  input  logic [WIDTH-1:0] dec_illegal,
  input  logic [WIDTH-1:0] dec_halt,
  input  logic [WIDTH-1:0] dec_mem,
  input  logic [1:0]       rob_free,
  input  logic [1:0]       rs_free,
  input  logic [1:0]       lsq_free,
  input  logic             squash,
  output logic [WIDTH-1:0] dispatch_en,
  output logic [1:0]       dispatch_cnt,
  output logic             stall,
  output logic             halted,
  output logic [ROB_W-1:0] rob_credits,
  output logic [RS_W-1:0]  rs_credits,
  output logic [LSQ_W-1:0] lsq_credits
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [ROB_W-1:0] rob_credits_reg, rob_credits_next;
  logic [RS_W-1:0]  rs_credits_reg, rs_credits_next;
  logic [LSQ_W-1:0] lsq_credits_reg, lsq_credits_next;
  logic             halted_reg;

  logic [WIDTH-1:0] present;
  logic [WIDTH-1:0] need_rs;
  logic [WIDTH-1:0] terminal;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slot
      assign present[gi]  = dec_valid[gi] | dec_illegal[gi];
      assign need_rs[gi]  = ~dec_mem[gi] & ~dec_halt[gi] & ~dec_illegal[gi];
      assign terminal[gi] = dec_halt[gi] | dec_illegal[gi];
    end
  endgenerate

  // In-order grant: each slot must fit in what is left after all older slots.
  logic [WIDTH-1:0] grant;
  logic             term_hit;
  int               rob_use, rs_use, lsq_use;
  logic             stop;
  always_comb begin
    grant    = '0;
    term_hit = 1'b0;
    rob_use  = 0;
    rs_use   = 0;
    lsq_use  = 0;
    stop     = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!stop) begin
        if (present[k] &&
            (rob_use + 1 <= int'(rob_credits_reg)) &&
            (rs_use + int'(need_rs[k]) <= int'(rs_credits_reg)) &&
            (lsq_use + int'(dec_mem[k]) <= int'(lsq_credits_reg))) begin
          grant[k] = 1'b1;
          rob_use  = rob_use + 1;
          rs_use   = rs_use + int'(need_rs[k]);
          lsq_use  = lsq_use + int'(dec_mem[k]);
          if (terminal[k]) begin
            term_hit = 1'b1;
            stop     = 1'b1;
          end
        end else begin
          stop = 1'b1;
        end
      end
    end
    // Nothing leaves dispatch outside RUN, while squashing, or in reset.
    if (reset || squash || (state_reg != ST_RUN)) begin
      grant    = '0;
      term_hit = 1'b0;
      rob_use  = 0;
      rs_use   = 0;
      lsq_use  = 0;
    end
  end

  int cnt;
  always_comb begin
    cnt = 0;
    for (int k = 0; k < WIDTH; k++) begin
      cnt = cnt + int'(grant[k]);
    end
  end

  assign dispatch_en  = grant;
  assign dispatch_cnt = 2'(cnt);

  always_comb begin
    stall = 1'b0;
    if (reset) begin
      stall = 1'b0;
    end else if (state_reg != ST_RUN) begin
      stall = 1'b1;
    end else begin
      stall = |(present & ~grant);
    end
  end

  int rob_tmp, rs_tmp, lsq_tmp;
  always_comb begin
    state_next       = state_reg;
    rob_tmp          = int'(rob_credits_reg) - rob_use + int'(rob_free);
    rs_tmp           = int'(rs_credits_reg) - rs_use + int'(rs_free);
    lsq_tmp          = int'(lsq_credits_reg) - lsq_use + int'(lsq_free);
    if (rob_tmp > ROB_SIZE) rob_tmp = ROB_SIZE;
    if (rs_tmp > RS_SIZE)   rs_tmp = RS_SIZE;
    if (lsq_tmp > LSQ_SIZE) lsq_tmp = LSQ_SIZE;
    rob_credits_next = ROB_W'(rob_tmp);
    rs_credits_next  = RS_W'(rs_tmp);
    lsq_credits_next = LSQ_W'(lsq_tmp);

    case (state_reg)
      ST_RUN:     if (term_hit) state_next = ST_HALTED;
      ST_HALTED:  state_next = ST_HALTED;
      ST_RECOVER: state_next = ST_RUN;
      default:    state_next = ST_RUN;
    endcase

    // Squash (and the recovery cycle) discard all in-flight work, so credits refill.
    if (squash) state_next = ST_RECOVER;
    if (squash || (state_reg == ST_RECOVER)) begin
      rob_credits_next = ROB_W'(ROB_SIZE);
      rs_credits_next  = RS_W'(RS_SIZE);
      lsq_credits_next = LSQ_W'(LSQ_SIZE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      rob_credits_reg <= ROB_W'(ROB_SIZE);
      rs_credits_reg  <= RS_W'(RS_SIZE);
      lsq_credits_reg <= LSQ_W'(LSQ_SIZE);
      halted_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rob_credits_reg <= rob_credits_next;
      rs_credits_reg  <= rs_credits_next;
      lsq_credits_reg <= lsq_credits_next;
      halted_reg      <= (state_next == ST_HALTED);
    end
  end

  assign halted      = halted_reg;
  assign rob_credits = rob_credits_reg;
  assign rs_credits  = rs_credits_reg;
  assign lsq_credits = lsq_credits_reg;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed testbench for dispatch_ctrl: hand-computed vectors for grant, stall,
// credits, halt shutdown, squash recovery and reset priority.
module tb_dispatch_ctrl;

  localparam int WIDTH    = 3;
  localparam int ROB_SIZE = 32;
  localparam int RS_SIZE  = 16;
  localparam int LSQ_SIZE = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] dec_valid, dec_illegal, dec_halt, dec_mem;
  logic [1:0] rob_free, rs_free, lsq_free;
  logic       squash;
  logic [2:0] dispatch_en;
  logic [1:0] dispatch_cnt;
  logic       stall, halted;
  logic [5:0] rob_credits;
  logic [4:0] rs_credits;
  logic [3:0] lsq_credits;

  int n_checks = 0;
  int n_fail   = 0;

  dispatch_ctrl #(
    .WIDTH(WIDTH), .ROB_SIZE(ROB_SIZE), .RS_SIZE(RS_SIZE), .LSQ_SIZE(LSQ_SIZE)
  ) dut (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_illegal(dec_illegal), .dec_halt(dec_halt), .dec_mem(dec_mem),
    .rob_free(rob_free), .rs_free(rs_free), .lsq_free(lsq_free), .squash(squash),
    .dispatch_en(dispatch_en), .dispatch_cnt(dispatch_cnt), .stall(stall), .halted(halted),
    .rob_credits(rob_credits), .rs_credits(rs_credits), .lsq_credits(lsq_credits)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] ill, input logic [2:0] h,
                       input logic [2:0] m);
    dec_valid = v; dec_illegal = ill; dec_halt = h; dec_mem = m;
    #1;
  endtask

  // Returning more entries than the free pool can hold is a protocol error.
  always @(negedge clock) begin
    if (!reset && !squash) begin
      assert (int'(rob_credits) - int'(dispatch_cnt) + int'(rob_free) <= ROB_SIZE)
        else $error("protocol: ROB over-free");
      assert (int'(lsq_credits) - $countones(dispatch_en & dec_mem) + int'(lsq_free) <= LSQ_SIZE)
        else $error("protocol: LSQ over-free");
      assert (int'(rs_credits) - $countones(dispatch_en & ~dec_mem & ~dec_halt & ~dec_illegal)
              + int'(rs_free) <= RS_SIZE)
        else $error("protocol: RS over-free");
    end
  end

  initial begin
    reset = 1'b1; squash = 1'b0;
    rob_free = 2'd0; rs_free = 2'd0; lsq_free = 2'd0;
    drive(3'b111, 3'b000, 3'b000, 3'b000);
    check("rst_en", dispatch_en, 3'b000);
    check("rst_stall", stall, 1'b0);
    tick();
    check("rst_rob", rob_credits, 32);
    check("rst_rs", rs_credits, 16);
    check("rst_lsq", lsq_credits, 8);
    check("rst_halted", halted, 1'b0);
    reset = 1'b0;

    // Three ALU ops with full credits
    drive(3'b111, 3'b000, 3'b000, 3'b000);
    check("alu3_en", dispatch_en, 3'b111);
    check("alu3_cnt", dispatch_cnt, 3);
    check("alu3_stall", stall, 1'b0);
    tick();
    drive(3'b000, 3'b000, 3'b000, 3'b000);
    check("alu3_rob", rob_credits, 29);
    check("alu3_rs", rs_credits, 13);
    check("idle_stall", stall, 1'b0);

    // Walk LSQ credits down to 1
    for (int i = 0; i < 2; i++) begin
      drive(3'b111, 3'b000, 3'b000, 3'b111);
      check("mem3_en", dispatch_en, 3'b111);
      tick();
    end
    drive(3'b001, 3'b000, 3'b000, 3'b001);
    check("mem1_en", dispatch_en, 3'b001);
    tick();
    check("lsq_one", lsq_credits, 1);
    // mem, mem, ALU with one LSQ credit, one LSQ entry released same cycle
    lsq_free = 2'd1;
    drive(3'b111, 3'b000, 3'b000, 3'b011);
    check("lsqlim_en", dispatch_en, 3'b001);
    check("lsqlim_cnt", dispatch_cnt, 1);
    check("lsqlim_stall", stall, 1'b1);
    tick();
    lsq_free = 2'd0;
    drive(3'b000, 3'b000, 3'b000, 3'b000);
    check("lsqnet_lsq", lsq_credits, 1);
    check("lsqnet_rob", rob_credits, 21);
    check("lsqnet_rs", rs_credits, 13);

    // Hole in the group
    drive(3'b101, 3'b000, 3'b000, 3'b000);
    check("hole_en", dispatch_en, 3'b001);
    check("hole_stall", stall, 1'b1);
    tick();
    drive(3'b000, 3'b000, 3'b000, 3'b000);
    check("hole_rob", rob_credits, 20);
    check("hole_rs", rs_credits, 12);

    // Fresh credits, then halt in slot 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(3'b111, 3'b000, 3'b010, 3'b000);
    check("halt_en", dispatch_en, 3'b011);
    check("halt_stall", stall, 1'b1);
    tick();
    check("halted", halted, 1'b1);
    check("halted_en", dispatch_en, 3'b000);
    check("halted_stall", stall, 1'b1);
    check("halted_rob", rob_credits, 30);
    check("halted_rs", rs_credits, 15);

    // Squash while halted, frees ignored
    squash = 1'b1; rob_free = 2'd3;
    drive(3'b111, 3'b000, 3'b000, 3'b000);
    check("squash_en", dispatch_en, 3'b000);
    tick();
    squash = 1'b0; rob_free = 2'd0;
    #1;
    check("rec_en", dispatch_en, 3'b000);
    check("rec_stall", stall, 1'b1);
    check("rec_rob", rob_credits, 32);
    check("rec_rs", rs_credits, 16);
    check("rec_lsq", lsq_credits, 8);
    tick();
    check("run_halted", halted, 1'b0);
    check("run_en", dispatch_en, 3'b111);
    tick();
    check("run_rob", rob_credits, 29);

    // Drain ROB with RS entries recycled every cycle
    rs_free = 2'd3;
    for (int i = 0; i < 9; i++) begin
      check("drain_en", dispatch_en, 3'b111);
      tick();
    end
    check("drain_rob", rob_credits, 2);
    check("drain_rs", rs_credits, 13);
    rs_free = 2'd2;
    drive(3'b011, 3'b000, 3'b000, 3'b000);
    check("drain_last_en", dispatch_en, 3'b011);
    tick();
    rs_free = 2'd0; rob_free = 2'd2;
    drive(3'b111, 3'b000, 3'b000, 3'b000);
    check("empty_rob", rob_credits, 0);
    check("empty_en", dispatch_en, 3'b000);
    check("empty_cnt", dispatch_cnt, 0);
    check("empty_stall", stall, 1'b1);
    tick();
    rob_free = 2'd0;
    #1;
    check("refill_rob", rob_credits, 2);
    check("refill_en", dispatch_en, 3'b011);
    check("refill_stall", stall, 1'b1);
    tick();
    check("refill_after_rob", rob_credits, 0);

    // Illegal in slot 0 is terminal; then reset beats squash out of HALTED
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(3'b110, 3'b001, 3'b000, 3'b000);
    check("ill_en", dispatch_en, 3'b001);
    check("ill_stall", stall, 1'b1);
    tick();
    check("ill_halted", halted, 1'b1);
    check("ill_rs", rs_credits, 16);
    reset = 1'b1; squash = 1'b1;
    drive(3'b111, 3'b000, 3'b000, 3'b000);
    check("rstsq_en", dispatch_en, 3'b000);
    check("rstsq_stall", stall, 1'b0);
    tick();
    reset = 1'b0; squash = 1'b0;
    #1;
    check("rstsq_halted", halted, 1'b0);
    check("rstsq_rob", rob_credits, 32);
    check("rstsq_en_run", dispatch_en, 3'b111);
    tick();
    drive(3'b000, 3'b000, 3'b000, 3'b000);
    check("final_rob", rob_credits, 29);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
